// File: rtl/plot_receiver_pkg.sv
// Shared constants, state encoding and address helper for plot_receiver.
// Optional feature macro: PLOT_BOUNDS_CHECK_EN (see plot_receiver.sv).
package plot_receiver_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 3;
    localparam int ENTRY_W   = FB_ADDR_W + COLOUR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // y*160 + x built from shifts, one bit wider than the address
    function automatic logic [FB_ADDR_W:0] lin_addr_160(
        input logic [6:0] y,
        input logic [7:0] x
    );
        logic [FB_ADDR_W:0] w_y;
        w_y = {9'd0, y};
        return (w_y << 7) + (w_y << 5) + {8'd0, x};
    endfunction

endpackage

// File: rtl/plot_receiver_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module plot_fifo
    import plot_receiver_pkg::*;
#(
    parameter int DW    = ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd];

    // storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// Plot command receiver: queues plots, clears the screen, writes framebuffer.
// Optional macro PLOT_BOUNDS_CHECK_EN drops off-screen plots and flags oob_err.
module plot_receiver
    import plot_receiver_pkg::*;
#(
    parameter int WIDTH      = SCREEN_W,
    parameter int HEIGHT     = SCREEN_H,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int FIFO_DEPTH = 8,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plot,
    input  logic [7:0]          x_in,
    input  logic [6:0]          y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                clear_req,
    input  logic                fb_ready,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                busy,
    output logic                overflow,
    output logic                oob_err
);

    localparam int EW = ADDR_W + COLOUR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH*HEIGHT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_overflow;
    logic              r_oob;
    logic [ADDR_W-1:0] w_addr;
    logic [EW-1:0]     w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_oob;

    generate
        if (WIDTH == 160) begin : g_shift
            assign w_addr = ADDR_W'(lin_addr_160(y_in, x_in));
        end else begin : g_mul
            assign w_addr = ADDR_W'(32'(y_in) * 32'(WIDTH) + 32'(x_in));
        end
    endgenerate

`ifdef PLOT_BOUNDS_CHECK_EN
    assign w_oob  = (32'(x_in) >= 32'(WIDTH)) | (32'(y_in) >= 32'(HEIGHT));
    assign w_push = plot & ~w_oob;
`else
    assign w_oob  = 1'b0;
    assign w_push = plot;
`endif

    assign w_pop = (r_state == ST_RUN) & ~w_empty & fb_ready;

    plot_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({w_addr, colour_in}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // clear sweep and run/clear sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        r_cnt <= '0;
                    end else if (fb_ready) begin
                        if (r_cnt == LAST) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (plot && w_oob) begin
                r_oob <= 1'b1;
            end
        end
    end

    // framebuffer port mux, forced quiet while reset is held
    always_comb begin
        fb_we   = 1'b0;
        fb_addr = '0;
        fb_data = '0;
        busy    = 1'b0;
        if (!rst) begin
            busy = (r_state == ST_CLEAR) | ~w_empty;
            if (r_state == ST_CLEAR) begin
                fb_we   = 1'b1;
                fb_addr = r_cnt;
                fb_data = BG_COLOUR;
            end else begin
                fb_we   = ~w_empty;
                fb_addr = w_head[EW-1:COLOUR_W];
                fb_data = w_head[COLOUR_W-1:0];
            end
        end
    end

    assign overflow = r_overflow;
    assign oob_err  = r_oob;

endmodule

// File: doc/plot_receiver.md
Name: plot_receiver

Overview:
- Consumer end of the pixel-plot interface driven by the game backend (`plot`, `x`, `y`, `colour`).
- Accepts one plot command per cycle with no backpressure and buffers it in a small FIFO.
- Converts each command to a linear framebuffer address and writes it out through a ready/valid framebuffer write port.
- Performs a full-screen background clear after reset and on request; plots arriving during a clear are queued and drawn after it.

Parameters:
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- ADDR_W, 15, framebuffer address width (must hold WIDTH*HEIGHT-1)
- FIFO_DEPTH, 8, command FIFO entries (power of two)
- BG_COLOUR, 3'b000, colour written during a clear

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- plot  in  1  command strobe; one command per cycle while high
- x_in  in  8  pixel x coordinate
- y_in  in  7  pixel y coordinate
- colour_in  in  3  pixel colour
- clear_req  in  1  single-cycle request for a full-screen clear
- fb_ready  in  1  framebuffer accepts the current write this cycle
- fb_we  out  1  framebuffer write valid
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  3  framebuffer write colour
- busy  out  1  high while in CLEAR or while the FIFO is non-empty
- overflow  out  1  sticky: a command was dropped because the FIFO was full
- oob_err  out  1  sticky: a command was out of range (see Optional Feature)

Behaviour:
- Reset (rst high, asynchronous):
  - state=CLEAR, clear counter=0, FIFO empty, overflow=0, oob_err=0.
  - All outputs are 0 while rst is high.
- Enqueue:
  - A command is pushed on each clk edge where plot=1.
  - Stored entry = {addr, colour}, where addr = y_in*WIDTH + x_in, truncated to ADDR_W.
  - For WIDTH=160 the multiply is implemented as (y<<7)+(y<<5); no multiplier.
  - Enqueue continues in every state, including CLEAR.
- FIFO:
  - Registered storage; read data is the head entry, presented combinationally.
  - Push while full and no pop in the same cycle: command dropped, overflow set to 1 until rst.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
- State CLEAR:
  - fb_we=1, fb_addr=clear counter, fb_data=BG_COLOUR.
  - The counter increments only on cycles where fb_ready=1.
  - When address WIDTH*HEIGHT-1 is accepted: state goes to RUN and the counter returns to 0.
  - The FIFO is not popped during CLEAR.
- State RUN:
  - fb_we = FIFO non-empty; fb_addr/fb_data = head entry.
  - Pop on fb_we & fb_ready.
  - fb_addr/fb_data are held stable while fb_we=1 and fb_ready=0.
- clear_req:
  - In RUN: go to CLEAR with counter=0 on the next edge. FIFO contents are retained and drained after the clear completes.
  - In CLEAR: the counter restarts at 0.
  - If clear_req coincides with the final clear write, the restart wins.
- Latency:
  - A plot at edge t appears on fb_we in the cycle after edge t, provided the FIFO was empty and state=RUN.
  - Throughput is 1 write/cycle while fb_ready=1.
- busy = (state==CLEAR) | FIFO non-empty.
- rst asserted mid-clear or mid-drain: pending commands are discarded and a new clear starts after rst deasserts.

Optional Feature:
- Macro: PLOT_BOUNDS_CHECK_EN.
- Defined:
  - A command with x_in>=WIDTH or y_in>=HEIGHT is not enqueued.
  - oob_err is set to 1 (sticky until rst).
  - An out-of-range command does not set overflow, even if the FIFO is full.
- Undefined:
  - All commands are enqueued, with addr truncated to ADDR_W.
  - oob_err is tied to 0.

Decomposition:
- Shared package:
  - Constants SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15, COLOUR_W=3.
  - State encoding CLEAR/RUN.
  - FIFO entry width, FB_ADDR_W+COLOUR_W.
- Sub-module plot_fifo:
  - Parameterised synchronous FIFO with push, pop, full, empty and head data.
  - Same clk/rst as the top.
  - Push-when-full-with-pop behaviour as specified above.

Test Plan:
1. Reset, fb_ready=1 constantly:
   - fb_we=1 with addr 0..19199 on consecutive cycles, data=000.
   - busy drops once the FIFO is also empty.
   - Exactly 19200 clear writes.
2. After the clear, plot x=5, y=3, colour=3'b100, fb_ready=1:
   - Next cycle fb_we=1, fb_addr=485, fb_data=100.
   - fb_we=0 the following cycle.
3. fb_ready=0, 10 consecutive plots (x=0..9, y=0):
   - First 8 are queued and overflow=1.
   - Then raise fb_ready: addresses 0..7 emerge in order and x=8,9 are never written.
4. Plots at (1,1) and (2,1) issued during a clear:
   - Written as addr 161 and 162 immediately after clear addr 19199, in order.
5. clear_req pulsed while 3 entries are queued in RUN:
   - Clear restarts from addr 0.
   - The 3 entries are written after address 19199.
6. With PLOT_BOUNDS_CHECK_EN, plot x=160, y=0:
   - No fb write occurs and oob_err=1.
   - Without the macro: fb_addr=160, oob_err=0.
